// File: rtl/tape_structure_writer_pkg.sv
// Shared types for the structure tape writer: tape element layout, error codes,
// open-index stack entries, writer states and prefix helpers.
// Purely declarative; no logic or timing of its own.
package tape_structure_writer_pkg;

    localparam int TAPE_IDX_W = 8;
    localparam int TAPE_DEPTH = 2 ** TAPE_IDX_W;

    typedef logic [TAPE_IDX_W-1:0] tape_index_t;

    // Highest index; a body element landing here would leave no room for the closing root.
    localparam tape_index_t TAPE_LAST_IDX = tape_index_t'(TAPE_DEPTH - 1);

    localparam logic [7:0] PFX_ROOT      = 8'h72;  // 'r'
    localparam logic [7:0] PFX_OPEN_OBJ  = 8'h7B;  // '{'
    localparam logic [7:0] PFX_CLOSE_OBJ = 8'h7D;  // '}'
    localparam logic [7:0] PFX_OPEN_ARR  = 8'h5B;  // '['
    localparam logic [7:0] PFX_CLOSE_ARR = 8'h5D;  // ']'

    typedef struct packed {
        logic [7:0]  prefix;
        logic [55:0] payload;
    } tape_elem_t;

    typedef enum logic [2:0] {
        TWE_NONE      = 3'd0,
        TWE_OVERFLOW  = 3'd1,
        TWE_UNDERFLOW = 3'd2,
        TWE_MISMATCH  = 3'd3,
        TWE_TAPE_FULL = 3'd4,
        TWE_UNCLOSED  = 3'd5
    } tape_write_error_e;

    typedef struct packed {
        tape_index_t idx;
        logic        is_array;
    } stack_entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ROOT_OPEN, S_RUN, S_PATCH, S_ROOT_CLOSE, S_ROOT_PATCH, S_DONE
    } writer_state_e;

    function automatic logic is_open(input logic [7:0] prefix);
        return (prefix == PFX_OPEN_OBJ) || (prefix == PFX_OPEN_ARR);
    endfunction

    function automatic logic is_close(input logic [7:0] prefix);
        return (prefix == PFX_CLOSE_OBJ) || (prefix == PFX_CLOSE_ARR);
    endfunction

    function automatic logic [7:0] open_prefix(input logic is_array);
        return is_array ? PFX_OPEN_ARR : PFX_OPEN_OBJ;
    endfunction

    // Builds an element whose payload is a zero-extended tape index.
    function automatic tape_elem_t mk_elem(input logic [7:0] prefix, input tape_index_t idx);
        tape_elem_t e;
        e.prefix  = prefix;
        e.payload = 56'(idx);
        return e;
    endfunction

endpackage

// File: rtl/tape_structure_writer_if.sv
// Element input handshake, document control and tape RAM write port of the writer.
// Wires only; the writer registers every write-port output.
// inReady gates element acceptance; upstream holds inElement while stalled.
interface tape_structure_writer_if;
    logic                                  start;
    logic                                  inValid;
    logic                                  inReady;
    logic                                  inLast;
    logic [63:0]                           inElement;
    logic                                  tapeWe;
    tape_structure_writer_pkg::tape_index_t tapeAddr;
    logic [63:0]                           tapeData;
    tape_structure_writer_pkg::tape_index_t tapeLength;
    logic                                  done;
    logic [2:0]                            error;

    modport slave (
        input  start, inValid, inLast, inElement,
        output inReady, tapeWe, tapeAddr, tapeData, tapeLength, done, error
    );

    modport master (
        output start, inValid, inLast, inElement,
        input  inReady, tapeWe, tapeAddr, tapeData, tapeLength, done, error
    );
endinterface

// File: rtl/tape_structure_writer_open_index_stack.sv
// LIFO of tape indices of currently open containers, with their container kind.
// Push/pop take effect at the next clock edge; top/full/empty reflect the current contents.
// No backpressure: caller checks full/empty before pushing or popping.
module tape_structure_writer_open_index_stack
    import tape_structure_writer_pkg::*;
#(
    parameter int MAX_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  stack_entry_t push_entry,
    output stack_entry_t top,
    output logic         full,
    output logic         empty
);
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int PW = $clog2(MAX_DEPTH + 1);

    logic [PW-1:0] sp_q, sp_d, sp_m1;
    stack_entry_t  mem_q [MAX_DEPTH];

    // Stack pointer update; clear wins, push and pop never coincide.
    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + PW'(1);
        end else if (pop) begin
            sp_d = sp_q - PW'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents beyond the pointer are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[sp_q[AW-1:0]] <= push_entry;
        end
    end

    assign sp_m1 = sp_q - PW'(1);
    assign top   = mem_q[sp_m1[AW-1:0]];
    assign full  = (sp_q == PW'(MAX_DEPTH));
    assign empty = (sp_q == '0);

endmodule

// File: rtl/tape_structure_writer.sv
// Writes the structure element stream to the tape RAM, adds roots, back-patches open elements.
// Latency: a write decided in cycle t is on the RAM port in cycle t+1.
// Backpressure: inReady drops for the patch cycle after each close and outside RUN or after an error.
module tape_structure_writer
    import tape_structure_writer_pkg::*;
#(
    parameter int MAX_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rstN,
    tape_structure_writer_if.slave  bus
);
    writer_state_e     state_q, state_d;
    tape_index_t       idx_q, idx_d;
    tape_index_t       patch_idx_q, patch_idx_d;
    tape_index_t       len_q, len_d;
    tape_index_t       addr_q, addr_d;
    logic              patch_arr_q, patch_arr_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    tape_elem_t        data_q, data_d;
    tape_write_error_e err_q, err_d;

    tape_elem_t   elem;
    logic         accept, elem_open;
    logic         stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    stack_entry_t stk_top, push_entry;

    assign elem                = bus.inElement;
    assign elem_open           = is_open(elem.prefix);
    assign bus.inReady         = (state_q == S_RUN) && (err_q == TWE_NONE);
    assign accept              = bus.inValid && bus.inReady;
    assign push_entry.idx      = idx_q;
    assign push_entry.is_array = (elem.prefix == PFX_OPEN_ARR);

    tape_structure_writer_open_index_stack #(.MAX_DEPTH(MAX_DEPTH)) u_stack (
        .clk        (clk),
        .rstN       (rstN),
        .clear      (stk_clear),
        .push       (stk_push),
        .pop        (stk_pop),
        .push_entry (push_entry),
        .top        (stk_top),
        .full       (stk_full),
        .empty      (stk_empty)
    );

    // Document sequencing: next state, next write and error detection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        last_d      = last_q;
        patch_idx_d = patch_idx_q;
        patch_arr_d = patch_arr_q;
        len_d       = len_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clear   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_ROOT_OPEN;
                    idx_d     = '0;
                    err_d     = TWE_NONE;
                    last_d    = 1'b0;
                    stk_clear = 1'b1;
                end
            end
            S_ROOT_OPEN: begin
                we_d    = 1'b1;
                addr_d  = '0;
                data_d  = mk_elem(PFX_ROOT, '0);
                idx_d   = tape_index_t'(1);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    if (is_close(elem.prefix)) begin
                        if (stk_empty) begin
                            err_d   = TWE_UNDERFLOW;
                            state_d = S_DONE;
                        end else if (stk_top.is_array != (elem.prefix == PFX_CLOSE_ARR)) begin
                            err_d   = TWE_MISMATCH;
                            state_d = S_DONE;
                        end else if (idx_q == TAPE_LAST_IDX) begin
                            err_d   = TWE_TAPE_FULL;
                            state_d = S_DONE;
                        end else begin
                            stk_pop     = 1'b1;
                            we_d        = 1'b1;
                            addr_d      = idx_q;
                            data_d      = mk_elem(elem.prefix, stk_top.idx);
                            idx_d       = idx_q + tape_index_t'(1);
                            patch_idx_d = stk_top.idx;
                            patch_arr_d = stk_top.is_array;
                            last_d      = bus.inLast;
                            state_d     = S_PATCH;
                        end
                    end else if (elem_open && stk_full) begin
                        err_d   = TWE_OVERFLOW;
                        state_d = S_DONE;
                    end else if (idx_q == TAPE_LAST_IDX) begin
                        err_d   = TWE_TAPE_FULL;
                        state_d = S_DONE;
                    end else begin
                        stk_push = elem_open;
                        we_d     = 1'b1;
                        addr_d   = idx_q;
                        data_d   = elem_open ? mk_elem(elem.prefix, '0) : elem;
                        idx_d    = idx_q + tape_index_t'(1);
                        state_d  = bus.inLast ? S_ROOT_CLOSE : S_RUN;
                    end
                end
            end
            S_PATCH: begin
                // idx_q already points one past the close, which is the patch payload.
                we_d    = 1'b1;
                addr_d  = patch_idx_q;
                data_d  = mk_elem(open_prefix(patch_arr_q), idx_q);
                state_d = last_q ? S_ROOT_CLOSE : S_RUN;
            end
            S_ROOT_CLOSE: begin
                if (!stk_empty) begin
                    err_d   = TWE_UNCLOSED;
                    state_d = S_DONE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    data_d  = mk_elem(PFX_ROOT, '0);
                    idx_d   = idx_q + tape_index_t'(1);
                    state_d = S_ROOT_PATCH;
                end
            end
            S_ROOT_PATCH: begin
                we_d    = 1'b1;
                addr_d  = '0;
                data_d  = mk_elem(PFX_ROOT, idx_q - tape_index_t'(1));
                len_d   = idx_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, bookkeeping and registered write port.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            err_q       <= TWE_NONE;
            last_q      <= 1'b0;
            patch_idx_q <= '0;
            patch_arr_q <= 1'b0;
            len_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            last_q      <= last_d;
            patch_idx_q <= patch_idx_d;
            patch_arr_q <= patch_arr_d;
            len_q       <= len_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign bus.tapeWe     = we_q;
    assign bus.tapeAddr   = addr_q;
    assign bus.tapeData   = data_q;
    assign bus.tapeLength = len_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.error      = err_q;

endmodule

// File: tb/tb_tape_structure_writer.sv
// Bench for tape_structure_writer: directed documents against a write-list model,
// every tape write compared in order, plus literal tapes for the reference documents.
module tb_tape_structure_writer;
    import tape_structure_writer_pkg::*;

    logic clk;
    logic rstN;
    tape_structure_writer_if bus();

    tape_structure_writer #(.MAX_DEPTH(32)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: expected write list, open-container stack, next index, error.
    int          exp_adr[$];
    logic [63:0] exp_dat[$];
    int          log_adr[$];
    logic [63:0] log_dat[$];
    int          ms_idx[$];
    bit          ms_arr[$];
    int          midx;
    int          merr;
    int          mlen;
    logic [63:0] doc[$];

    int          lit1_a [7] = '{0, 1, 2, 3, 1, 4, 0};
    logic [63:0] lit1_d [7] = '{64'h7200_0000_0000_0000, 64'h5B00_0000_0000_0000,
                                64'h7500_0000_0000_0000, 64'h5D00_0000_0000_0001,
                                64'h5B00_0000_0000_0004, 64'h7200_0000_0000_0000,
                                64'h7200_0000_0000_0004};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] p, input int v);
        logic [63:0] r;
        r = 64'(v);
        r[63:56] = p;
        return r;
    endfunction

    task automatic expect_wr(input int a, input logic [63:0] d);
        exp_adr.push_back(a);
        exp_dat.push_back(d);
    endtask

    task automatic model_start();
        ms_idx.delete(); ms_arr.delete();
        log_adr.delete(); log_dat.delete();
        merr = 0; mlen = 0; midx = 1;
        expect_wr(0, mk(8'h72, 0));
    endtask

    task automatic model_elem(input logic [63:0] e, input bit last);
        logic [7:0] p;
        int o;
        bit oa;
        p = e[63:56];
        if (merr != 0) return;
        if (p == 8'h7D || p == 8'h5D) begin
            if (ms_idx.size() == 0) merr = 2;
            else if (ms_arr[ms_arr.size()-1] != (p == 8'h5D)) merr = 3;
            else if (midx == TAPE_DEPTH - 1) merr = 4;
            else begin
                o  = ms_idx.pop_back();
                oa = ms_arr.pop_back();
                expect_wr(midx, mk(p, o));
                expect_wr(o, mk(oa ? 8'h5B : 8'h7B, midx + 1));
                midx++;
            end
        end else if (p == 8'h7B || p == 8'h5B) begin
            if (ms_idx.size() == 32) merr = 1;
            else if (midx == TAPE_DEPTH - 1) merr = 4;
            else begin
                ms_idx.push_back(midx);
                ms_arr.push_back(p == 8'h5B);
                expect_wr(midx, mk(p, 0));
                midx++;
            end
        end else begin
            if (midx == TAPE_DEPTH - 1) merr = 4;
            else begin
                expect_wr(midx, e);
                midx++;
            end
        end
        if (merr == 0 && last) begin
            if (ms_idx.size() != 0) merr = 5;
            else begin
                expect_wr(midx, mk(8'h72, 0));
                expect_wr(0, mk(8'h72, midx));
                mlen = midx + 1;
            end
        end
    endtask

    // Every write on the RAM port is compared, in order, with the model's list.
    always @(negedge clk) begin
        if (bus.tapeWe === 1'b1) begin
            log_adr.push_back(int'(bus.tapeAddr));
            log_dat.push_back(bus.tapeData);
            if (exp_adr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected write: addr %0d data %h, no write required", bus.tapeAddr, bus.tapeData);
            end else begin
                chk("write addr", 64'(bus.tapeAddr), 64'(exp_adr.pop_front()));
                chk("write data", bus.tapeData, exp_dat.pop_front());
            end
        end
    end

    task automatic send(input string tag, input logic [63:0] e, input bit last, input bit expect_stall);
        int n;
        n = 0;
        bus.inValid = 1'b1;
        bus.inElement = e;
        bus.inLast = last;
        while (bus.inReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s accept timeout: inReady %b, required 1", tag, bus.inReady);
        end
        @(negedge clk);
        bus.inValid = 1'b0;
        bus.inLast = 1'b0;
        if (expect_stall) chk({tag, " stall after close"}, 64'(bus.inReady), 64'd0);
    endtask

    task automatic run_doc(input string tag, input bit use_last, input int mid_start);
        logic [63:0] e;
        logic [7:0]  p;
        bit last;
        bit cl;
        bus.start = 1'b1;
        model_start();
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < doc.size(); i++) begin
            if (i == mid_start) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            e = doc[i];
            p = e[63:56];
            last = use_last && (i == doc.size() - 1);
            model_elem(e, last);
            cl = (p == 8'h7D || p == 8'h5D) && (merr == 0);
            send(tag, e, last, cl);
            if (merr != 0) break;
        end
    endtask

    task automatic finish_doc(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, 64'(bus.done), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, " error"}, 64'(bus.error), 64'(merr));
        chk({tag, " inReady"}, 64'(bus.inReady), 64'd0);
        if (merr == 0) chk({tag, " tapeLength"}, 64'(bus.tapeLength), 64'(mlen));
        chk({tag, " pending writes"}, 64'(exp_adr.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " tapeWe"}, 64'(bus.tapeWe), 64'd0);
        chk({tag, " tapeAddr"}, 64'(bus.tapeAddr), 64'd0);
        chk({tag, " tapeData"}, bus.tapeData, 64'd0);
        chk({tag, " tapeLength"}, 64'(bus.tapeLength), 64'd0);
        chk({tag, " done"}, 64'(bus.done), 64'd0);
        chk({tag, " error"}, 64'(bus.error), 64'd0);
        chk({tag, " inReady"}, 64'(bus.inReady), 64'd0);
    endtask

    task automatic check_doc1_literal(input string tag);
        chk({tag, " write count"}, 64'(log_adr.size()), 64'd7);
        for (int i = 0; i < 7 && i < log_adr.size(); i++) begin
            chk({tag, " literal addr"}, 64'(log_adr[i]), 64'(lit1_a[i]));
            chk({tag, " literal data"}, log_dat[i], lit1_d[i]);
        end
        chk({tag, " literal length"}, 64'(bus.tapeLength), 64'd5);
    endtask

    task automatic load_doc1();
        doc.delete();
        doc.push_back(mk(8'h5B, 0));
        doc.push_back(mk(8'h75, 0));
        doc.push_back(mk(8'h5D, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0;
        bus.start = 1'b0;
        bus.inValid = 1'b0;
        bus.inLast = 1'b0;
        bus.inElement = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rstN = 1'b1;
        @(negedge clk);

        // "[1]"
        load_doc1();
        run_doc("doc1", 1'b1, -1);
        finish_doc("doc1");
        check_doc1_literal("doc1");
        chk("doc1 model length", 64'(mlen), 64'd5);

        // "{[]}" with an ignored start pulse mid-document and inValid held across patches
        doc.delete();
        doc.push_back(mk(8'h7B, 0));
        doc.push_back(mk(8'h5B, 0));
        doc.push_back(mk(8'h5D, 0));
        doc.push_back(mk(8'h7D, 0));
        run_doc("nested", 1'b1, 1);
        finish_doc("nested");
        chk("nested write count", 64'(log_adr.size()), 64'd9);
        if (log_adr.size() == 9) begin
            chk("nested close ] addr", 64'(log_adr[3]), 64'd3);
            chk("nested close ] data", log_dat[3], 64'h5D00_0000_0000_0002);
            chk("nested patch [ addr", 64'(log_adr[4]), 64'd2);
            chk("nested patch [ data", log_dat[4], 64'h5B00_0000_0000_0004);
            chk("nested close } data", log_dat[5], 64'h7D00_0000_0000_0001);
            chk("nested patch { addr", 64'(log_adr[6]), 64'd1);
            chk("nested patch { data", log_dat[6], 64'h7B00_0000_0000_0005);
        end
        chk("nested literal length", 64'(bus.tapeLength), 64'd6);

        // {"a":[1,2],"b":{}} with strings and scalars carrying payloads
        doc.delete();
        doc.push_back(mk(8'h7B, 0));
        doc.push_back(mk(8'h22, 32'h0012_3456));
        doc.push_back(mk(8'h5B, 0));
        doc.push_back(mk(8'h75, 1));
        doc.push_back(mk(8'h75, 2));
        doc.push_back(mk(8'h5D, 0));
        doc.push_back(mk(8'h22, 32'h00AB_CDEF));
        doc.push_back(mk(8'h7B, 0));
        doc.push_back(mk(8'h7D, 0));
        doc.push_back(mk(8'h7D, 0));
        run_doc("mixed", 1'b1, -1);
        finish_doc("mixed");

        // Top-level scalar
        doc.delete();
        doc.push_back(mk(8'h6C, 32'h7FFF_FFFF));
        run_doc("scalar", 1'b1, -1);
        finish_doc("scalar");

        // Mismatch
        doc.delete();
        doc.push_back(mk(8'h7B, 0));
        doc.push_back(mk(8'h5D, 0));
        run_doc("mismatch", 1'b0, -1);
        finish_doc("mismatch");
        chk("mismatch literal error", 64'(bus.error), 64'd3);

        // Overflow: 33 opens
        doc.delete();
        for (int i = 0; i < 33; i++) doc.push_back(mk(8'h5B, 0));
        run_doc("overflow", 1'b0, -1);
        finish_doc("overflow");
        chk("overflow literal error", 64'(bus.error), 64'd1);

        // Underflow on a fresh document
        doc.delete();
        doc.push_back(mk(8'h5D, 0));
        run_doc("underflow", 1'b0, -1);
        finish_doc("underflow");
        chk("underflow literal error", 64'(bus.error), 64'd2);

        // Unclosed container at inLast
        doc.delete();
        doc.push_back(mk(8'h5B, 0));
        run_doc("unclosed", 1'b1, -1);
        finish_doc("unclosed");

        // Tape full
        doc.delete();
        for (int i = 0; i < TAPE_DEPTH - 1; i++) doc.push_back(mk(8'h75, i));
        run_doc("tapefull", 1'b0, -1);
        finish_doc("tapefull");
        chk("tapefull literal error", 64'(bus.error), 64'd4);

        // Reset mid-document, then a clean document
        doc.delete();
        doc.push_back(mk(8'h5B, 0));
        doc.push_back(mk(8'h75, 9));
        run_doc("midreset", 1'b0, -1);
        #2;
        rstN = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_adr.delete();
        exp_dat.delete();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        load_doc1();
        run_doc("after reset", 1'b1, -1);
        finish_doc("after reset");
        check_doc1_literal("after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
